// File: rtl/cpu_clk_rst_ctrl.sv
// Clock-enable, divided CPU clock and reset sequencer for the multi-cycle CPU.
// Generates clk_CPU from clk with run / single-step / halt control and a cycle counter.
module cpu_clk_rst_ctrl #(
  parameter int DIV_WIDTH     = 8,
  parameter int RST_CYCLES    = 4,
  parameter int RST_CNT_WIDTH = 4,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 step,
  output logic                 clk_CPU,
  output logic                 cpu_en,
  output logic                 rst_cpu,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    ST_RST  = 2'b00,
    ST_PARK = 2'b01,
    ST_LOW  = 2'b10,
    ST_HIGH = 2'b11
  } state_e;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [RST_CNT_WIDTH-1:0] RST_LAST = RST_CNT_WIDTH'(RST_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [RST_CNT_WIDTH-1:0] rst_cnt_q, rst_cnt_d;
  logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic                   step_pending_q, step_pending_d;
  logic                   rst_cpu_q, rst_cpu_d;
  logic                   clk_cpu_q, clk_cpu_d;
  logic                   cpu_en_q, cpu_en_d;
  logic [CNT_WIDTH-1:0]   cycle_count_q, cycle_count_d;
  logic                   step_set;
  logic                   step_take;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    div_cnt_d     = div_cnt_q;
    div_d         = div_q;
    cycle_count_d = cycle_count_q;
    step_take     = 1'b0;
    step_set      = step && (mode == MODE_STEP) && (state_q != ST_RST);

    unique case (state_q)
      ST_RST: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RST_LAST) state_d = ST_PARK;
      end
      ST_PARK: begin
        if ((mode == MODE_RUN) || ((mode == MODE_STEP) && step_pending_q)) begin
          state_d   = ST_LOW;
          div_cnt_d = '0;
          div_d     = div;
          step_take = 1'b1;
        end
      end
      ST_LOW: begin
        if (div_cnt_q == div_q) begin
          state_d       = ST_HIGH;
          div_cnt_d     = '0;
          cycle_count_d = cycle_count_q + 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (div_cnt_q == div_q) begin
          div_cnt_d = '0;
          // A period is only ever ended here, so clk_CPU always finishes high.
          if (mode == MODE_RUN) begin
            state_d = ST_LOW;
            div_d   = div;
          end else begin
            state_d = ST_PARK;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RST;
    endcase

    // A new request wins over consumption so a step arriving on the consume cycle survives.
    if (step_set)                             step_pending_d = 1'b1;
    else if (step_take || (mode == MODE_RUN)) step_pending_d = 1'b0;
    else                                      step_pending_d = step_pending_q;

    clk_cpu_d = (state_d != ST_LOW);
    cpu_en_d  = (state_q == ST_LOW) && (state_d == ST_HIGH);
    rst_cpu_d = (state_d == ST_RST);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RST;
      rst_cnt_q      <= '0;
      div_cnt_q      <= '0;
      div_q          <= '0;
      step_pending_q <= 1'b0;
      rst_cpu_q      <= 1'b1;
      clk_cpu_q      <= 1'b1;
      cpu_en_q       <= 1'b0;
      cycle_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      div_cnt_q      <= div_cnt_d;
      div_q          <= div_d;
      step_pending_q <= step_pending_d;
      rst_cpu_q      <= rst_cpu_d;
      clk_cpu_q      <= clk_cpu_d;
      cpu_en_q       <= cpu_en_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  assign clk_CPU     = clk_cpu_q;
  assign cpu_en      = cpu_en_q;
  assign rst_cpu     = rst_cpu_q;
  assign cycle_count = cycle_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_cpu_clk_rst_ctrl.sv
// Self-checking bench for cpu_clk_rst_ctrl: per-scenario tasks plus a cpu_en scoreboard
// holding the expected cycle and cycle_count of every CPU clock rising edge.
module tb_cpu_clk_rst_ctrl;

  localparam logic [1:0] S_RST  = 2'b00;
  localparam logic [1:0] S_PARK = 2'b01;
  localparam logic [1:0] S_LOW  = 2'b10;
  localparam logic [1:0] S_HIGH = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [7:0]  div;
  logic        step;
  logic        clk_CPU;
  logic        cpu_en;
  logic        rst_cpu;
  logic [31:0] cycle_count;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    int unsigned cnt;
  } ev_t;
  ev_t exp_q[$];

  cpu_clk_rst_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .div         (div),
    .step        (step),
    .clk_CPU     (clk_CPU),
    .cpu_en      (cpu_en),
    .rst_cpu     (rst_cpu),
    .cycle_count (cycle_count),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Advance one clk and score any cpu_en pulse against the expected queue.
  task automatic tick();
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (cpu_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_cpu_en cyc=%0d got pulse count=%0d expected no pulse", cyc, cycle_count);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || cycle_count !== e.cnt) begin
          failures++;
          $display("FAIL cpu_en_event got cyc=%0d count=%0d expected cyc=%0d count=%0d",
                   cyc, cycle_count, e.cyc, e.cnt);
        end
      end
    end
  endtask

  task automatic push_ev(int c, int unsigned n);
    ev_t e;
    e.cyc = c;
    e.cnt = n;
    exp_q.push_back(e);
  endtask

  // Reset, release and let the sequencer reach PARK.
  task automatic start(logic [1:0] m, logic [7:0] d);
    rst  = 1'b1;
    step = 1'b0;
    mode = m;
    div  = d;
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    logic [1:0] exp_s;
    logic       exp_b;
    int         base;
    rst = 1'b1; step = 1'b0; mode = 2'b00; div = 8'd0;
    tick();
    tick();
    checks++;
    if ({state, rst_cpu, clk_CPU, cpu_en, cycle_count} !== {S_RST, 1'b1, 1'b1, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL reset_values got state=%0d rst_cpu=%b clk_CPU=%b cpu_en=%b count=%0d expected 0 1 1 0 0",
               state, rst_cpu, clk_CPU, cpu_en, cycle_count);
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_b = (k < 4);
      exp_s = (k < 4) ? S_RST : S_PARK;
      checks++;
      if ({rst_cpu, state} !== {exp_b, exp_s}) begin
        failures++;
        $display("FAIL reset_release k=%0d got rst_cpu=%b state=%0d expected rst_cpu=%b state=%0d",
                 k, rst_cpu, state, exp_b, exp_s);
      end
    end
    base = cyc;
    for (int n = 1; n <= 10; n++) push_ev(base + 2 * n, n);
    for (int r = 1; r <= 20; r++) begin
      tick();
      exp_b = (r % 2 == 0);
      exp_s = exp_b ? S_HIGH : S_LOW;
      checks++;
      if ({clk_CPU, state} !== {exp_b, exp_s}) begin
        failures++;
        $display("FAIL div0_toggle r=%0d got clk_CPU=%b state=%0d expected clk_CPU=%b state=%0d",
                 r, clk_CPU, state, exp_b, exp_s);
      end
    end
    checks++;
    if (cycle_count !== 32'd10) begin
      failures++;
      $display("FAIL div0_count got=%0d expected=10", cycle_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_missing_cpu_en got=%0d outstanding expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_div_change();
    logic exp_b;
    int   base;
    start(2'b00, 8'd3);
    base = cyc;
    push_ev(base + 5, 1);
    push_ev(base + 11, 2);
    push_ev(base + 15, 3);
    push_ev(base + 19, 4);
    for (int r = 1; r <= 20; r++) begin
      tick();
      if (r == 2) div = 8'd1;
      if (r <= 4)      exp_b = 1'b0;
      else if (r <= 8) exp_b = 1'b1;
      else             exp_b = ((r - 9) % 4) >= 2;
      checks++;
      if (clk_CPU !== exp_b) begin
        failures++;
        $display("FAIL div_change r=%0d got clk_CPU=%b expected=%b", r, clk_CPU, exp_b);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL div_change_missing_cpu_en got=%0d outstanding expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [1:0] exp_step_state(int r);
    int p;
    p = (r <= 9) ? r : r - 9;
    if (p == 1)       return S_PARK;
    else if (p <= 4)  return S_LOW;
    else if (p <= 7)  return S_HIGH;
    else if (p == 8)  return S_PARK;
    else if (r <= 9)  return S_PARK;
    else if (p <= 11) return S_LOW;
    else if (p <= 14) return S_HIGH;
    else              return S_PARK;
  endfunction

  task automatic test_step();
    logic [1:0] exp_s;
    int         base;
    start(2'b01, 8'd2);
    base = cyc;
    push_ev(base + 5, 1);
    push_ev(base + 14, 2);
    push_ev(base + 21, 3);
    for (int r = 1; r <= 29; r++) begin
      step = (r == 1) || (r == 10) || (r == 12) || (r == 14);
      tick();
      exp_s = exp_step_state(r);
      checks++;
      if ({state, clk_CPU} !== {exp_s, exp_s != S_LOW}) begin
        failures++;
        $display("FAIL step_seq r=%0d got state=%0d clk_CPU=%b expected state=%0d", r, state, clk_CPU, exp_s);
      end
    end
    step = 1'b0;
    checks++;
    if (cycle_count !== 32'd3) begin
      failures++;
      $display("FAIL step_count got=%0d expected=3", cycle_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL step_missing_cpu_en got=%0d outstanding expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // A step level still high on the cycle PARK consumes the pending step earns a second period.
  task automatic test_back_to_back();
    logic [1:0] exp_s [10];
    int         base;
    exp_s = '{S_PARK, S_LOW, S_HIGH, S_PARK, S_LOW, S_HIGH, S_PARK, S_PARK, S_PARK, S_PARK};
    start(2'b01, 8'd0);
    base = cyc;
    push_ev(base + 3, 1);
    push_ev(base + 6, 2);
    for (int r = 1; r <= 10; r++) begin
      step = (r <= 2);
      tick();
      checks++;
      if (state !== exp_s[r-1]) begin
        failures++;
        $display("FAIL step_hold r=%0d got state=%0d expected=%0d", r, state, exp_s[r-1]);
      end
    end
    step = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL step_hold_missing_cpu_en got=%0d outstanding expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_halt();
    logic [1:0] exp_s;
    logic [1:0] hm;
    int         base;
    for (int i = 0; i < 2; i++) begin
      hm = (i == 0) ? 2'b10 : 2'b11;
      start(2'b00, 8'd3);
      base = cyc;
      push_ev(base + 5, 1);
      for (int r = 1; r <= 16; r++) begin
        if (r == 2) mode = hm;
        tick();
        exp_s = (r <= 4) ? S_LOW : (r <= 8) ? S_HIGH : S_PARK;
        checks++;
        if ({state, clk_CPU} !== {exp_s, exp_s != S_LOW}) begin
          failures++;
          $display("FAIL halt mode=%0d r=%0d got state=%0d clk_CPU=%b expected state=%0d",
                   hm, r, state, clk_CPU, exp_s);
        end
      end
      checks++;
      if (cycle_count !== 32'd1) begin
        failures++;
        $display("FAIL halt_count mode=%0d got=%0d expected=1", hm, cycle_count);
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL halt_missing_cpu_en got=%0d outstanding expected=0", exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_s;
    int         base;
    start(2'b00, 8'd0);
    base = cyc;
    for (int n = 1; n <= 7; n++) push_ev(base + 2 * n, n);
    repeat (14) tick();
    checks++;
    if ({state, cycle_count} !== {S_HIGH, 32'd7}) begin
      failures++;
      $display("FAIL pre_reset got state=%0d count=%0d expected state=3 count=7", state, cycle_count);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({clk_CPU, rst_cpu, cpu_en, cycle_count, state} !== {1'b1, 1'b1, 1'b0, 32'd0, S_RST}) begin
      failures++;
      $display("FAIL mid_reset got clk_CPU=%b rst_cpu=%b cpu_en=%b count=%0d state=%0d expected 1 1 0 0 0",
               clk_CPU, rst_cpu, cpu_en, cycle_count, state);
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_s = (k <= 3) ? S_RST : (k == 4) ? S_PARK : S_LOW;
      checks++;
      if (state !== exp_s) begin
        failures++;
        $display("FAIL resequence k=%0d got state=%0d expected=%0d", k, state, exp_s);
      end
    end
    push_ev(cyc + 1, 1);
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_missing_cpu_en got=%0d outstanding expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_ignored_step();
    logic [1:0] exp_s;
    int         base;
    start(2'b00, 8'd2);
    base = cyc;
    push_ev(base + 4, 1);
    push_ev(base + 10, 2);
    push_ev(base + 16, 3);
    for (int r = 1; r <= 26; r++) begin
      step = (r == 2) || (r == 3) || (r == 7);
      if (r == 14) mode = 2'b01;
      tick();
      if (r <= 18) exp_s = (((r - 1) % 6) < 3) ? S_LOW : S_HIGH;
      else         exp_s = S_PARK;
      checks++;
      if (state !== exp_s) begin
        failures++;
        $display("FAIL ignored_step r=%0d got state=%0d expected=%0d", r, state, exp_s);
      end
    end
    step = 1'b0;
    checks++;
    if (cycle_count !== 32'd3) begin
      failures++;
      $display("FAIL ignored_count got=%0d expected=3", cycle_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL ignored_missing_cpu_en got=%0d outstanding expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst  = 1'b1;
    mode = 2'b00;
    div  = 8'd0;
    step = 1'b0;
    test_reset();
    test_div_change();
    test_step();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    test_ignored_step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
